// File: rtl/arq_pkg.sv
// Shared ARQ types: sequence numbers, ACK payload, and modular sequence comparison.
package arq_pkg;

    localparam int ARQ_SEQ_W  = 4;
    localparam int ARQ_WINDOW = 1 << (ARQ_SEQ_W - 1);

    typedef logic [ARQ_SEQ_W-1:0] seq_t;

    typedef struct packed {
        seq_t seq;
    } ack_pkt_t;

    // True when cand lies 1..WINDOW ahead of ref_seq, modulo 2^SEQ_W.
    function automatic logic seq_newer(seq_t cand, seq_t ref_seq);
        seq_t d;
        d = seq_t'(cand - ref_seq);
        return (d != '0) && (int'(d) <= ARQ_WINDOW);
    endfunction

endpackage

// File: rtl/arq_ack_gap_timer.sv
// Loadable down-counter that saturates at zero; zero flag marks expiry.
module arq_ack_gap_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/arq_ack_tx.sv
// Receiver-side ACK transmitter: coalesces cumulative-ACK requests, sends the newest,
// re-sends it a bounded number of times with idle gaps, then goes silent.
module arq_ack_tx
    import arq_pkg::*;
#(
    parameter int SEQ_W   = 4,
    parameter int REPEATS = 2,
    parameter int GAP     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEQ_W-1:0] req_seq,
    input  logic             req_trigger,
    output logic             req_did_trigger,
    output logic             ack_valid,
    input  logic             ack_ready,
    output logic [SEQ_W-1:0] ack_seq,
    output logic             busy
);

    localparam int RW = (REPEATS > 0) ? $clog2(REPEATS + 1) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    if (GAP < 1) begin : g_bad_gap
        $error("arq_ack_tx: GAP must be >= 1");
    end
    if (SEQ_W != ARQ_SEQ_W) begin : g_bad_seq_w
        $error("arq_ack_tx: SEQ_W must match the ARQ package sequence width");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } state_t;

    state_t        state;
    seq_t          cur_seq;
    seq_t          new_seq;
    logic          have_new;
    logic [RW-1:0] rep_cnt;
    ack_pkt_t      ack_q;

    logic req_newer;
    logic handshake;
    logic gap_load;
    logic gap_dec;
    logic gap_zero;

    // Comparison is against the ACK currently owned, not a pending coalesced one.
    assign req_newer       = req_trigger && seq_newer(req_seq, cur_seq);
    assign handshake       = ack_valid && ack_ready;
    assign req_did_trigger = req_trigger;
    assign busy            = (state != ST_IDLE);
    assign ack_seq         = ack_q.seq;

    assign gap_load = (state == ST_SEND) && handshake && !req_newer && !have_new
                      && (rep_cnt != '0);
    assign gap_dec  = (state == ST_GAP) && !req_newer;

    arq_ack_gap_timer #(.W(GW)) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (GW'(GAP - 1)),
        .dec      (gap_dec),
        .zero     (gap_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cur_seq   <= '0;
            new_seq   <= '0;
            have_new  <= 1'b0;
            rep_cnt   <= '0;
            ack_q     <= '0;
            ack_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Any request starts a fresh ACK, even one equal to cur_seq.
                    if (req_trigger) begin
                        cur_seq   <= req_seq;
                        ack_q.seq <= req_seq;
                        rep_cnt   <= RW'(REPEATS);
                        ack_valid <= 1'b1;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (handshake) begin
                        if (req_newer) begin
                            cur_seq   <= req_seq;
                            ack_q.seq <= req_seq;
                            rep_cnt   <= RW'(REPEATS);
                            have_new  <= 1'b0;
                        end else if (have_new) begin
                            cur_seq   <= new_seq;
                            ack_q.seq <= new_seq;
                            rep_cnt   <= RW'(REPEATS);
                            have_new  <= 1'b0;
                        end else if (rep_cnt == '0) begin
                            ack_valid <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            rep_cnt   <= rep_cnt - 1'b1;
                            ack_valid <= 1'b0;
                            state     <= ST_GAP;
                        end
                    end else if (req_newer) begin
                        new_seq  <= req_seq;
                        have_new <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (req_newer) begin
                        cur_seq   <= req_seq;
                        ack_q.seq <= req_seq;
                        rep_cnt   <= RW'(REPEATS);
                        ack_valid <= 1'b1;
                        state     <= ST_SEND;
                    end else if (gap_zero) begin
                        ack_valid <= 1'b1;
                        state     <= ST_SEND;
                    end
                end
                default: begin
                    ack_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arq_ack_tx.sv
// Bench for arq_ack_tx: per-cycle reference model, scoreboard of expected ACK payloads.
module tb_arq_ack_tx;

    localparam int SEQ_W   = 4;
    localparam int REPEATS = 2;
    localparam int GAP     = 8;
    localparam int MOD     = 1 << SEQ_W;
    localparam int WIN     = 1 << (SEQ_W - 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [SEQ_W-1:0] req_seq = '0;
    logic             req_trigger = 1'b0;
    logic             req_did_trigger;
    logic             ack_valid;
    logic             ack_ready = 1'b0;
    logic [SEQ_W-1:0] ack_seq;
    logic             busy;

    arq_ack_tx #(.SEQ_W(SEQ_W), .REPEATS(REPEATS), .GAP(GAP)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_seq         (req_seq),
        .req_trigger     (req_trigger),
        .req_did_trigger (req_did_trigger),
        .ack_valid       (ack_valid),
        .ack_ready       (ack_ready),
        .ack_seq         (ack_seq),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hs_seen = 0;
    logic [SEQ_W-1:0] exp_q[$];

    // Reference model: an ACK is either on offer, waiting out a gap, or absent.
    bit m_offer, m_waiting, m_pend;
    int m_cur, m_pseq, m_left, m_wait;
    bit exp_valid, exp_busy, mon_en;
    int exp_seq;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit is_newer(input int s, input int cur);
        int d;
        d = (((s - cur) % MOD) + MOD) % MOD;
        return (d >= 1) && (d <= WIN);
    endfunction

    task automatic model_reset();
        m_offer = 0; m_waiting = 0; m_pend = 0;
        m_cur = 0; m_pseq = 0; m_left = 0; m_wait = 0;
        exp_valid = 0; exp_busy = 0; exp_seq = 0;
        exp_q.delete();
    endtask

    task automatic step(input bit trig, input int seq, input bit rdy);
        bit idle, nw, hs;
        @(negedge clk);
        #1;
        req_trigger = trig;
        req_seq     = SEQ_W'(seq);
        ack_ready   = rdy;
        exp_valid   = m_offer;
        exp_busy    = m_offer || m_waiting;
        exp_seq     = m_cur;
        #1;
        check("did_trigger", int'(req_did_trigger), int'(trig));
        idle = !m_offer && !m_waiting;
        nw   = trig && (idle || is_newer(seq, m_cur));
        hs   = m_offer && rdy;
        if (hs) exp_q.push_back(SEQ_W'(m_cur));
        if (idle) begin
            if (trig) begin
                m_cur = seq; m_left = REPEATS; m_offer = 1;
            end
        end else if (m_offer) begin
            if (hs) begin
                if (nw) begin
                    m_cur = seq; m_left = REPEATS; m_pend = 0;
                end else if (m_pend) begin
                    m_cur = m_pseq; m_left = REPEATS; m_pend = 0;
                end else if (m_left == 0) begin
                    m_offer = 0;
                end else begin
                    m_left--; m_offer = 0; m_waiting = 1; m_wait = GAP;
                end
            end else if (nw) begin
                m_pseq = seq; m_pend = 1;
            end
        end else begin
            if (nw) begin
                m_cur = seq; m_left = REPEATS; m_offer = 1; m_waiting = 0;
            end else begin
                m_wait--;
                if (m_wait == 0) begin
                    m_waiting = 0; m_offer = 1;
                end
            end
        end
    endtask

    task automatic idle_cycles(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, rdy);
    endtask

    // Monitor: compares pre-edge outputs against the model and pops the scoreboard on handshakes.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && mon_en) begin
                check("ack_valid", int'(ack_valid), int'(exp_valid));
                check("busy", int'(busy), int'(exp_busy));
                if (ack_valid && exp_valid) check("ack_seq_offer", int'(ack_seq), exp_seq);
                if (ack_valid && ack_ready) begin
                    hs_seen++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected_ack actual=%0d required=none at %0t",
                                 ack_seq, $time);
                    end else begin
                        logic [SEQ_W-1:0] e;
                        e = exp_q.pop_front();
                        if (ack_seq !== e) begin
                            errors++;
                            $display("FAIL sb_ack_seq actual=%0d required=%0d at %0t",
                                     ack_seq, e, $time);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int h0;
        mon_en = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_ack_valid", int'(ack_valid), 0);
        check("rst_ack_seq", int'(ack_seq), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_did_trigger", int'(req_did_trigger), 0);
        #1 rst_n = 1'b1;
        mon_en = 1;

        // Single ACK: sent once plus REPEATS re-sends, then silence.
        h0 = hs_seen;
        step(1, 3, 1);
        idle_cycles(45, 1);
        check("s1_handshakes", hs_seen - h0, 1 + REPEATS);
        check("s1_silent", int'(ack_valid), 0);

        // Coalescing under stall: 4 and 5 are superseded by 6.
        step(1, 3, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) step(1, 4, 0);
            else if (i == 4) step(1, 5, 0);
            else if (i == 6) step(1, 6, 0);
            else step(0, 0, 0);
        end
        idle_cycles(50, 1);

        // Duplicate and stale requests during a gap are ignored; a newer one restarts.
        step(1, 3, 1);
        step(0, 0, 1);
        idle_cycles(2, 1);
        step(1, 3, 1);
        step(0, 0, 1);
        step(1, 1, 1);
        idle_cycles(3, 1);
        step(1, 7, 1);
        idle_cycles(45, 1);

        // Wrap 15 -> 0 is newer; 10 is too far ahead of 0 and dropped.
        step(1, 15, 0);
        step(1, 0, 1);
        step(0, 0, 1);
        step(1, 10, 1);
        idle_cycles(45, 1);

        // Asynchronous reset while an ACK is stalled.
        step(1, 5, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        #2;
        rst_n = 1'b0;
        req_trigger = 1'b0;
        ack_ready = 1'b0;
        #1;
        check("arst_ack_valid", int'(ack_valid), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_ack_seq", int'(ack_seq), 0);
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        h0 = hs_seen;
        idle_cycles(20, 1);
        check("arst_no_replay", hs_seen - h0, 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            bit t, r;
            t = ($urandom_range(0, 99) < ((i % 300) < 150 ? 25 : 4));
            r = ($urandom_range(0, 99) < 70);
            step(t, int'($urandom_range(0, MOD - 1)), r);
        end

        idle_cycles(60, 1);
        check("final_silent", int'(ack_valid), 0);
        check("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
